// File: rtl/wb_ram_ws.sv
// Single-port Wishbone RAM slave with byte lanes, programmable wait states and cycle abort.
// Define WB_RAM_WS_OUTREG_EN to add a registered read-data stage (ack latency 2 instead of 1).
module wb_ram_ws #(
  parameter int size  = 'h800,
  parameter int width = 16,
  parameter int waits = 0,
  parameter int aw    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cyc,
  input  logic               stb,
  input  logic               we,
  input  logic [aw-1:0]      adr,
  input  logic [width/8-1:0] sel,
  input  logic [width-1:0]   dat_i,
  output logic [width-1:0]   dat_o,
  output logic               ack,
  output logic               stall
);

  localparam int ab    = $clog2(size);
  localparam int lanes = width / 8;
`ifdef WB_RAM_WS_OUTREG_EN
  localparam int depth = 2;
`else
  localparam int depth = 1;
`endif

  if (width < 8 || (width % 8) != 0) begin : g_bad_width
    $error("wb_ram_ws: width must be a non-zero multiple of 8");
  end
  if (size < 2 || (size & (size - 1)) != 0) begin : g_bad_size
    $error("wb_ram_ws: size must be a power of two, at least 2");
  end
  if (waits < 0 || waits > 15) begin : g_bad_waits
    $error("wb_ram_ws: waits must be in 0..15");
  end
  if (aw < ab) begin : g_bad_aw
    $error("wb_ram_ws: address port narrower than the RAM index");
  end

  logic valid;
  logic accept;

  assign valid  = cyc & stb;
  assign accept = valid & ~stall & ~rst;

  if (waits == 0) begin : g_nowait
    assign stall = 1'b0;
  end else begin : g_wait
    logic [3:0] cnt;

    // Reset forces a stall so a held request is never seen as accepted.
    assign stall = valid & (rst | (cnt != 4'(waits)));

    always_ff @(posedge clk) begin
      if (rst || !valid || !stall) begin
        cnt <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  logic [ab-1:0]    word_adr;
  logic [width-1:0] mem [size];
  logic [width-1:0] rd_q;

  assign word_adr = adr[ab-1:0];

  always_ff @(posedge clk) begin
    if (accept) begin
      if (we) begin
        for (int i = 0; i < lanes; i++) begin
          if (sel[i]) begin
            mem[word_adr][8*i +: 8] <= dat_i[8*i +: 8];
          end
        end
      end else begin
        rd_q <= mem[word_adr];
      end
    end
  end

  logic [depth-1:0] vld;
  logic [depth-1:0] tag_rd;

  // Dropping cyc flushes every stage so a stale ack never reaches a later cycle.
  always_ff @(posedge clk) begin
    if (rst || !cyc) begin
      vld    <= '0;
      tag_rd <= '0;
    end else begin
      vld[0]    <= accept;
      tag_rd[0] <= accept & ~we;
      for (int i = 1; i < depth; i++) begin
        vld[i]    <= vld[i-1];
        tag_rd[i] <= tag_rd[i-1];
      end
    end
  end

  assign ack = vld[depth-1] & cyc;

`ifdef WB_RAM_WS_OUTREG_EN
  logic [width-1:0] out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else if (cyc && tag_rd[0]) begin
      out_q <= rd_q;
    end
  end

  assign dat_o = out_q;
`else
  assign dat_o = rd_q;
`endif

  // Upper address bits alias by design; not every tag stage feeds logic in every build.
  logic unused_ok;
  assign unused_ok = ^{adr, tag_rd};

endmodule

// File: tb/tb_wb_ram_ws.sv
// Bench for wb_ram_ws: dut0 is 2048x32 with no waits, dut1 is 16x16 with 3 wait states.
// A transaction-level scoreboard checks stall, ack and read data on every cycle.
module tb_wb_ram_ws;
`ifdef WB_RAM_WS_OUTREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        cyc0, stb0, we0, ack0, stall0;
  logic [15:0] adr0;
  logic [3:0]  sel0;
  logic [31:0] dati0, dato0;
  logic        cyc1, stb1, we1, ack1, stall1;
  logic [15:0] adr1;
  logic [1:0]  sel1;
  logic [15:0] dati1, dato1;

  wb_ram_ws #(.size('h800), .width(32), .waits(0), .aw(16)) u_dut0 (
    .clk(clk), .rst(rst), .cyc(cyc0), .stb(stb0), .we(we0), .adr(adr0), .sel(sel0),
    .dat_i(dati0), .dat_o(dato0), .ack(ack0), .stall(stall0));

  wb_ram_ws #(.size(16), .width(16), .waits(3), .aw(16)) u_dut1 (
    .clk(clk), .rst(rst), .cyc(cyc1), .stb(stb1), .we(we1), .adr(adr1), .sel(sel1),
    .dat_i(dati1), .dat_o(dato1), .ack(ack1), .stall(stall1));

  typedef struct {
    bit          rd;
    int          dev;
    int          due;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    bit          we;
    logic [15:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  pend_t       pq[$];
  vec_t        rqs[$];
  logic [31:0] rdq[$];
  int          ack_cyc[$];
  logic [31:0] mm [2][2048];
  int          kk [2];
  int          t;
  int          vectors;
  int          miscompares;

  function automatic int waits_of(int d);   return (d != 0) ? 3 : 0; endfunction
  function automatic int abits_of(int d);   return (d != 0) ? 4 : 11; endfunction
  function automatic int lanes_of(int d);   return (d != 0) ? 2 : 4; endfunction
  function automatic logic [31:0] mask_of(int d); return (d != 0) ? 32'h0000ffff : 32'hffffffff; endfunction
  function automatic logic [31:0] pat(int a);     return 32'ha5a50000 | 32'(a); endfunction
  function automatic bit f_ack(int d);            return (d != 0) ? ack1 : ack0; endfunction
  function automatic bit f_stall(int d);          return (d != 0) ? stall1 : stall0; endfunction
  function automatic logic [31:0] f_dat(int d);   return (d != 0) ? {16'h0, dato1} : dato0; endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(int d, bit c, bit s, bit w, logic [15:0] a, logic [3:0] sl, logic [31:0] di);
    if (d == 0) begin
      cyc0 = c; stb0 = s; we0 = w; adr0 = a; sel0 = sl; dati0 = di;
    end else begin
      cyc1 = c; stb1 = s; we1 = w; adr1 = a; sel1 = sl[1:0]; dati1 = di[15:0];
    end
  endtask

  // Scoreboard: a request is accepted once it has been valid for waits+1 consecutive
  // cycles; its ack is due L cycles later unless cyc drops or reset intervenes first.
  task automatic mon(int d);
    bit c, s, w, valid, exp_st, acc, due_now, exp_ack;
    logic [15:0] a;
    logic [3:0]  sl;
    logic [31:0] di;
    int idx, aa;
    if (d == 0) begin
      c = cyc0; s = stb0; w = we0; a = adr0; sl = sel0; di = dati0;
    end else begin
      c = cyc1; s = stb1; w = we1; a = adr1; sl = {2'b00, sel1}; di = {16'h0, dati1};
    end
    valid = c && s;
    if (rst) exp_st = (waits_of(d) > 0) && valid;
    else     exp_st = (waits_of(d) > 0) && valid && (kk[d] != waits_of(d));
    acc = !rst && valid && !exp_st;
    chk($sformatf("d%0d stall t=%0d", d, t), 32'(f_stall(d)), 32'(exp_st));
    idx = -1;
    foreach (pq[i]) if (idx < 0 && pq[i].dev == d) idx = i;
    due_now = (idx >= 0) && (pq[idx].due == t);
    exp_ack = c && due_now;
    chk($sformatf("d%0d ack t=%0d", d, t), 32'(f_ack(d)), 32'(exp_ack));
    if (exp_ack && pq[idx].rd) chk($sformatf("d%0d dat_o t=%0d", d, t), f_dat(d), pq[idx].data);
    if (due_now) pq.delete(idx);
    if (rst || !c) begin
      for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].dev == d) pq.delete(i);
    end
    if (rst || !valid || acc) kk[d] = 0;
    else kk[d]++;
    if (acc) begin
      aa = int'(a) & ((1 << abits_of(d)) - 1);
      if (w) begin
        for (int i = 0; i < lanes_of(d); i++) if (sl[i]) mm[d][aa][8*i +: 8] = di[8*i +: 8];
        pq.push_back('{rd: 1'b0, dev: d, due: t + L, data: 32'h0});
      end else begin
        pq.push_back('{rd: 1'b1, dev: d, due: t + L, data: mm[d][aa] & mask_of(d)});
      end
    end
  endtask

  task automatic smp();
    @(negedge clk);
    t++;
    mon(0);
    mon(1);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin smp(); adv(); end
  endtask

  task automatic req(int d, bit w, logic [15:0] a, logic [3:0] sl, logic [31:0] di, output int stalls);
    drive(d, 1'b1, 1'b1, w, a, sl, di);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (!f_stall(d)) begin adv(); return; end
      stalls++;
      adv();
    end
    vectors++; miscompares++;
    $display("FAIL d%0d accept timeout adr 0x%0h: got no accept, expected one within 40 cycles", d, a);
  endtask

  task automatic wait_ack(int d, output int n, output logic [31:0] data);
    drive(d, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    n = 99;
    data = 32'h0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (f_ack(d)) begin n = i + 1; data = f_dat(d); adv(); return; end
      adv();
    end
    vectors++; miscompares++;
    $display("FAIL d%0d ack timeout: got no ack, expected one within 20 cycles", d);
  endtask

  task automatic xfer(int d, bit w, logic [15:0] a, logic [3:0] sl, logic [31:0] di,
                      output logic [31:0] data, output int stalls, output int lat);
    req(d, w, a, sl, di, stalls);
    wait_ack(d, lat, data);
  endtask

  // Presents rqs pipelined on device d; records ack cycles (0 = first presentation) and data.
  task automatic run_seq(int d, int budget);
    int i, c;
    bit acc;
    i = 0; c = 0;
    rdq.delete(); ack_cyc.delete();
    drive(d, 1'b1, 1'b1, rqs[0].we, rqs[0].adr, rqs[0].sel, rqs[0].dat);
    while (ack_cyc.size() < rqs.size() && c < budget) begin
      smp();
      acc = (i < rqs.size()) && !f_stall(d);
      if (f_ack(d)) begin ack_cyc.push_back(c); rdq.push_back(f_dat(d)); end
      adv();
      c++;
      if (acc) begin
        i++;
        if (i < rqs.size()) drive(d, 1'b1, 1'b1, rqs[i].we, rqs[i].adr, rqs[i].sel, rqs[i].dat);
        else drive(d, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
      end
    end
    if (ack_cyc.size() < rqs.size()) begin
      vectors++; miscompares++;
      $display("FAIL d%0d sequence timeout: got %0d acks, expected %0d", d, ack_cyc.size(), rqs.size());
      drive(d, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    end
  endtask

  vec_t tbl[13];

  initial begin
    logic [31:0] data;
    int st, lat, first;

    tbl[0]  = '{1'b1, 16'h0005, 4'hf, 32'h11223344, 32'h0};
    tbl[1]  = '{1'b1, 16'h0005, 4'h5, 32'haabbccdd, 32'h0};
    tbl[2]  = '{1'b0, 16'h0005, 4'h0, 32'h0,        32'h11bb33dd};
    tbl[3]  = '{1'b1, 16'h0005, 4'h0, 32'hffffffff, 32'h0};
    tbl[4]  = '{1'b0, 16'h0005, 4'hf, 32'h0,        32'h11bb33dd};
    tbl[5]  = '{1'b1, 16'h0803, 4'hf, 32'hcafef00d, 32'h0};
    tbl[6]  = '{1'b0, 16'h0003, 4'h0, 32'h0,        32'hcafef00d};
    tbl[7]  = '{1'b1, 16'h0007, 4'h8, 32'h5a000000, 32'h0};
    tbl[8]  = '{1'b0, 16'h0007, 4'h0, 32'h0,        32'h5aa50007};
    tbl[9]  = '{1'b0, 16'h07ff, 4'h0, 32'h0,        32'ha5a507ff};
    tbl[10] = '{1'b1, 16'h0010, 4'h2, 32'h00001200, 32'h0};
    tbl[11] = '{1'b0, 16'h0010, 4'h0, 32'h0,        32'ha5a51210};
    tbl[12] = '{1'b0, 16'hffff, 4'h0, 32'h0,        32'ha5a507ff};

    vectors = 0; miscompares = 0; t = 0;
    kk[0] = 0; kk[1] = 0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    adv(); adv();

    // reset state, with both masters requesting during reset
    drive(0, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 32'h0);
    smp();
    chk("reset ack0", 32'(ack0), 32'h0);
    chk("reset ack1", 32'(ack1), 32'h0);
    chk("reset stall0", 32'(stall0), 32'h0);
    chk("reset stall1", 32'(stall1), 32'h1);
`ifdef WB_RAM_WS_OUTREG_EN
    chk("reset dat_o0", dato0, 32'h0);
`endif
    adv();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    idle(2);

    // fill both RAMs with a known pattern
    for (int a = 0; a < 2048; a++) req(0, 1'b1, 16'(a), 4'hf, pat(a), st);
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    for (int a = 0; a < 16; a++) req(1, 1'b1, 16'(a), 4'h3, pat(a), st);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    idle(L + 1);

    // byte lanes, sel=0 write, aliasing
    foreach (tbl[i]) begin
      xfer(0, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, data, st, lat);
      chk($sformatf("tbl%0d stalls", i), 32'(st), 32'h0);
      chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(L));
      if (!tbl[i].we) chk($sformatf("tbl%0d rdata", i), data, tbl[i].exp);
    end

    // wait states on the 16-bit device
    xfer(1, 1'b1, 16'h0005, 4'h3, 32'h0000beef, data, st, lat);
    chk("ws write stalls", 32'(st), 32'd3);
    chk("ws write latency", 32'(lat), 32'(L));
    xfer(1, 1'b0, 16'h0005, 4'h0, 32'h0, data, st, lat);
    chk("ws read stalls", 32'(st), 32'd3);
    chk("ws read latency", 32'(lat), 32'(L));
    chk("ws read data", data, 32'h0000beef);

    // 4-read burst at 3 waits: accepts at 3,7,11,15
    rqs.delete();
    for (int i = 0; i < 4; i++) rqs.push_back('{1'b0, 16'(i), 4'h0, 32'h0, 32'h0});
    run_seq(1, 60);
    chk("burst4 acks", 32'(ack_cyc.size()), 32'd4);
    if (ack_cyc.size() == 4) begin
      chk("burst4 first ack", 32'(ack_cyc[0]), 32'(3 + L));
      chk("burst4 last ack", 32'(ack_cyc[3]), 32'(15 + L));
      for (int i = 0; i < 4; i++) chk($sformatf("burst4 data%0d", i), rdq[i], pat(i) & 32'hffff);
    end

    // read-after-write in consecutive cycles
    rqs.delete();
    rqs.push_back('{1'b1, 16'h0030, 4'hf, 32'h13572468, 32'h0});
    rqs.push_back('{1'b0, 16'h0030, 4'h0, 32'h0, 32'h0});
    run_seq(0, 20);
    chk("raw acks", 32'(ack_cyc.size()), 32'd2);
    if (ack_cyc.size() == 2) begin
      chk("raw spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'd1);
      chk("raw data", rdq[1], 32'h13572468);
    end

    // 100-read stream: one ack per cycle, in order
    rqs.delete();
    for (int i = 0; i < 100; i++) rqs.push_back('{1'b0, 16'(16'h100 + i), 4'h0, 32'h0, 32'h0});
    run_seq(0, 200);
    chk("stream acks", 32'(ack_cyc.size()), 32'd100);
    if (ack_cyc.size() == 100) begin
      chk("stream first ack", 32'(ack_cyc[0]), 32'(L));
      chk("stream last ack", 32'(ack_cyc[99]), 32'(99 + L));
      for (int i = 0; i < 100; i++) chk($sformatf("stream data%0d", i), rdq[i], pat(256 + i));
    end
    idle(2);

    // abort: cyc drops right after the third accept
    for (int c = 0; c < 3; c++) begin
      drive(0, 1'b1, 1'b1, 1'b1, 16'(16'h20 + c), 4'hf, 32'hd0000000 | 32'(c));
      smp(); adv();
    end
    drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      smp();
      chk($sformatf("abort ack c%0d", c), 32'(ack0), 32'h0);
      adv();
    end
    for (int c = 0; c < 3; c++) begin
      xfer(0, 1'b0, 16'(16'h20 + c), 4'h0, 32'h0, data, st, lat);
      chk($sformatf("abort readback%0d", c), data, 32'hd0000000 | 32'(c));
    end

    // reset pulse in the middle of a read stream
    for (int c = 0; c < 8; c++) begin
      rst = (c == 3);
      drive(0, 1'b1, 1'b1, 1'b0, 16'(16'h40 + c), 4'h0, 32'h0);
      smp();
      if (c == 4) chk("midrst ack", 32'(ack0), 32'h0);
      adv();
    end
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    idle(3);
    xfer(0, 1'b0, 16'h0040, 4'h0, 32'h0, data, st, lat);
    chk("midrst readback", data, pat(64));
    xfer(0, 1'b0, 16'h0005, 4'h0, 32'h0, data, st, lat);
    chk("midrst contents", data, 32'h11bb33dd);

    // reset during a stalled request restarts the wait count
    drive(1, 1'b1, 1'b1, 1'b0, 16'h0002, 4'h0, 32'h0);
    first = -1;
    for (int c = 0; c < 12 && first < 0; c++) begin
      rst = (c == 2);
      smp();
      if (!stall1 && !rst) first = c;
      adv();
    end
    rst = 1'b0;
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    chk("rst restarts wait", 32'(first), 32'd6);
    idle(L + 2);

    // randomized traffic on both devices, including aborts, withdrawals and resets
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 2; d++)
        drive(d, $urandom_range(0, 19) != 0, $urandom_range(0, 2) != 0, 1'($urandom),
              16'($urandom), 4'($urandom), $urandom);
      rst = ($urandom_range(0, 99) == 0);
      smp();
      adv();
    end
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_ram_ws.md
# wb_ram_ws

Parametrised single-port RAM slave for the J1 Wishbone fabric, the next generation of the fixed 2048x16 Wishbone RAM. Adds configurable data width with byte-lane write enables, programmable wait states driven through the pipelined-mode `stall` signal, and cycle-abort handling. An optional registered read-data stage is compiled in for timing-critical targets. It sits on any Wishbone slave port: program/data memory for the J1 core, or a DMA buffer.

## Interface
- `size`, default `'h800`: depth in words; power of two, at least 2.
- `width`, default `16`: data width in bits; a multiple of 8; elaboration error otherwise.
- `waits`, default `0`: wait states per access, 0..15; stall cycles inserted before each acceptance.
- `wb` (`if_wb.slave`); all signals below are members of this interface:
- `wb.clk`  in  1  sole clock; all logic on its rising edge.
- `wb.rst`  in  1  reset, synchronous, active-high.
- `wb.cyc`  in  1  bus cycle in progress.
- `wb.stb`  in  1  request strobe.
- `wb.we`  in  1  1 = write, 0 = read.
- `wb.adr`  in  ≥ $clog2(size)  word address; only `[$clog2(size)-1:0]` decoded; upper bits alias.
- `wb.sel`  in  width/8  byte-lane enables; bit i enables `dat_i[8i+7:8i]` on writes; ignored on reads.
- `wb.dat_i`  in  width  write data.
- `wb.dat_o`  out  width  read data; valid only in the cycle `ack`=1 for a read.
- `wb.ack`  out  1  one-cycle acknowledge per accepted request.
- `wb.stall`  out  1  request not accepted this cycle.

## Operation
- valid = cyc & stb. accept = valid & ~stall & ~rst.
- Wait-state counter `cnt` (4 bits), reset 0:
  - `waits`=0: stall tied 0; `cnt` unused.
  - `waits`>0: stall = valid & (cnt != waits). `cnt` increments each cycle valid & stall. It clears to 0 on accept, and also on any cycle with valid=0, so a withdrawn strobe restarts the wait count.
- In the accept cycle, the RAM is enabled at address `adr[$clog2(size)-1:0]`.
  - Write: byte lanes with `sel[i]`=1 are updated; other lanes are unchanged.
  - sel=0 on a write: no lane is updated, but the write is still acked.
  - Read: full word.
- Ack pipeline: a shift register of depth L, where L=1 without the macro and L=2 with it. Stage 0 loads accept.
  - Each stage carries a read/write tag so `dat_o` can be qualified.
  - `ack` = last stage & cyc.
- Abort: cyc=0 clears all ack stages in the same clock edge, so pending acks never appear in a later cycle.
  - Writes already accepted remain committed.
- Back-to-back: with `waits`=0, one request is accepted per cycle indefinitely. Read-after-write to the same address in consecutive cycles returns the new data.
- Reset mid-operation: pending acks are discarded, `cnt` is cleared, and no request is accepted while rst=1. RAM contents are preserved.

## Timing
- Reset values: ack=0, cnt=0. stall=0 for `waits`=0; stall = valid for `waits`>0 while rst=1. dat_o=0 with the macro; undefined until the first read ack without it.
- Acceptance: a request first presented at cycle t is accepted at cycle t+waits (stall high at t..t+waits-1).
- Ack timing:
  - Ack latency from accept is L cycles: ack at t+waits+1 without the macro, t+waits+2 with it.
  - Throughput is one access per (waits+1) cycles.
- dat_o is held stable from ack until the next read ack when the macro is enabled. Without the macro it follows the RAM output register.

## Configuration
- `WB_RAM_WS_OUTREG_EN` defined:
  - An extra register is placed after the RAM read port, and the ack pipeline depth is 2.
  - dat_o resets to 0 and updates only on read-tagged completions.
- Undefined:
  - dat_o is driven directly from the synchronous RAM output, and the ack pipeline depth is 1.
- Only latency changes between the two builds. Ordering, stall behaviour and abort behaviour are identical.

## Test plan
- **Single-cycle reads and writes.** `width`=16, `waits`=0. Write 0xBEEF to address 5 with sel=2'b11, then read address 5. Expect ack 1 cycle after each accept and dat_o=0xBEEF. stall stays 0 throughout.
- **Byte lanes.** `width`=32. Write 0x11223344 with sel=4'hF, then 0xAABBCCDD with sel=4'b0101, then read. Expect 0x11BB33DD. A write with sel=0 is acked and leaves the data unchanged.
- **Wait states.** `waits`=3. Hold a read request from cycle 0. Expect stall high in cycles 0–2, accept at cycle 3, and ack at cycle 4 (cycle 5 with the macro). A 4-request burst completes 4 acks in 16 cycles.
- **Abort.** `waits`=0 with the macro enabled. Issue 3 back-to-back writes, then drop cyc in the cycle after the last accept. Expect no ack afterwards. All 3 locations hold the new data when read back.
- **Reset mid-burst.** Assert rst for 1 cycle during a read stream. Expect ack=0 and cnt=0 the following cycle. The next request is serviced normally, and prior RAM contents are intact.
- **Aliasing and throughput.** `size`='h800. Write address 0x0803 and read 0x0003; expect the same data. A 100-read `waits`=0 stream produces exactly 100 acks, in order and with no gaps.
